// File: rtl/ov7670_capture.sv
// OV7670 parallel-bus capture: assembles RGB565 pixels from the PCLK byte stream and
// reports pixel coordinates, end-of-frame strobes and a per-frame geometry error flag.
module ov7670_capture #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned V_ACTIVE = 480
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        vsync,
    input  logic        href,
    input  logic [7:0]  data,
    output logic [9:0]  outX,
    output logic [8:0]  outY,
    output logic [15:0] pixelValue,
    output logic        pixelValid,
    output logic        frameDone,
    output logic        frameErr
);

    localparam int unsigned XW = $clog2(H_ACTIVE + 1);
    localparam int unsigned YW = $clog2(V_ACTIVE + 1);
    localparam logic [XW-1:0] XMax = XW'(H_ACTIVE);
    localparam logic [YW-1:0] YMax = YW'(V_ACTIVE);

    typedef enum logic [1:0] {StWaitVs, StVblank, StActive} state_e;

    state_e        state_q;
    logic [XW-1:0] x_q;
    logic [YW-1:0] y_q;
    logic          phase_q;
    logic [7:0]    hi_q;
    logic          err_q;
    logic          href_q;

    logic          in_active, byte_lo, emit, line_start, line_end, frame_end;
    logic          phase_next, err_next;
    logic [XW-1:0] x_next;
    logic [YW-1:0] y_next;

    always_comb begin
        in_active  = (state_q == StActive);
        byte_lo    = in_active && href && phase_q;
        emit       = byte_lo && (x_q < XMax) && (y_q < YMax);
        line_start = in_active && href && !href_q;
        // vsync rising mid-line closes the line just like an href fall
        line_end   = in_active && ((href_q && !href) || (vsync && href));
        frame_end  = in_active && vsync;
        phase_next = href ? ~phase_q : phase_q;
        x_next     = (byte_lo && (x_q != XMax)) ? x_q + XW'(1) : x_q;
        y_next     = (line_end && (y_q != YMax)) ? y_q + YW'(1) : y_q;
        err_next   = err_q
                   | (byte_lo && (x_q == XMax))
                   | (line_start && (y_q == YMax))
                   | (line_end && (phase_next || (x_next < XMax)))
                   | (frame_end && (y_next < YMax));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StWaitVs;
            x_q        <= '0;
            y_q        <= '0;
            phase_q    <= 1'b0;
            hi_q       <= '0;
            err_q      <= 1'b0;
            href_q     <= 1'b0;
            outX       <= '0;
            outY       <= '0;
            pixelValue <= '0;
            pixelValid <= 1'b0;
            frameDone  <= 1'b0;
            frameErr   <= 1'b0;
        end else begin
            href_q     <= href;
            pixelValid <= emit;
            frameDone  <= frame_end;
            if (emit) begin
                pixelValue <= {hi_q, data};
                outX       <= 10'(x_q);
                outY       <= 9'(y_q);
            end
            if (frame_end) begin
                frameErr <= err_next;
            end
            unique case (state_q)
                StWaitVs: begin
                    if (vsync) state_q <= StVblank;
                end
                StVblank: begin
                    x_q     <= '0;
                    y_q     <= '0;
                    phase_q <= 1'b0;
                    err_q   <= 1'b0;
                    if (!vsync) state_q <= StActive;
                end
                StActive: begin
                    if (href) begin
                        phase_q <= ~phase_q;
                        if (!phase_q) hi_q <= data;
                    end
                    x_q   <= x_next;
                    err_q <= err_next;
                    if (line_end) begin
                        x_q     <= '0;
                        y_q     <= y_next;
                        phase_q <= 1'b0;
                    end
                    if (frame_end) state_q <= StVblank;
                end
                default: state_q <= StWaitVs;
            endcase
        end
    end

endmodule

// File: tb/tb_ov7670_capture.sv
// Randomized frame-level bench for ov7670_capture; expectations come from a per-line
// byte-count model of what the camera stream should yield.
module tb_ov7670_capture;

    localparam int H = 4;
    localparam int V = 6;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        vsync = 1'b0;
    logic        href = 1'b0;
    logic [7:0]  data = 8'h00;
    logic [9:0]  outX;
    logic [8:0]  outY;
    logic [15:0] pixelValue;
    logic        pixelValid, frameDone, frameErr;

    int checks = 0;
    int errors = 0;
    bit armed = 1'b0;
    logic [9:0]  ex = '0;
    logic [8:0]  ey = '0;
    logic [15:0] ev = '0;
    logic        efe = 1'b0;
    logic [7:0]  pat [4] = '{8'hF8, 8'h00, 8'h07, 8'hE0};

    always #5 clk = ~clk;

    ov7670_capture #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
        .clk        (clk),
        .reset      (reset),
        .vsync      (vsync),
        .href       (href),
        .data       (data),
        .outX       (outX),
        .outY       (outY),
        .pixelValue (pixelValue),
        .pixelValid (pixelValid),
        .frameDone  (frameDone),
        .frameErr   (frameErr)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input logic exp_pv, input logic exp_fd);
        check("pixelValid", 32'(pixelValid), 32'(exp_pv));
        check("frameDone", 32'(frameDone), 32'(exp_fd));
        check("outX", 32'(outX), 32'(ex));
        check("outY", 32'(outY), 32'(ey));
        check("pixelValue", 32'(pixelValue), 32'(ev));
        check("frameErr", 32'(frameErr), 32'(efe));
    endtask

    task automatic cycle(input logic vs, input logic hr, input logic [7:0] d,
                         input logic exp_pv, input logic exp_fd);
        @(negedge clk);
        vsync = vs;
        href  = hr;
        data  = d;
        @(posedge clk);
        #1;
        check_outputs(exp_pv, exp_fd);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        armed = 1'b0;
        ex = '0;
        ey = '0;
        ev = '0;
        efe = 1'b0;
        check_outputs(1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    // One frame: vsync low, nlines lines of bytes, then vsync rise and blanking.
    task automatic run_frame(input int nlines, input int bad_line, input int bad_len,
                             input bit vs_last, input bit directed, input int rst_line);
        logic [7:0] hi, d;
        bit pv, fd, last, exp_err;
        int len;
        hi = '0;
        exp_err = (nlines != V);
        for (int l = 0; l < nlines; l++)
            if (l == bad_line && bad_len != 2 * H) exp_err = 1'b1;
        repeat (2) cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        for (int l = 0; l < nlines; l++) begin
            len = (l == bad_line) ? bad_len : 2 * H;
            for (int b = 0; b < len; b++) begin
                if (l == rst_line && b == 4) pulse_reset();
                d    = (directed && l == 0 && b < 4) ? pat[b] : 8'($urandom);
                last = vs_last && (l == nlines - 1) && (b == len - 1);
                pv   = armed && (b % 2 == 1) && (l < V) && (b / 2 < H);
                fd   = armed && last;
                if (pv) begin
                    ex = 10'(b / 2);
                    ey = 9'(l);
                    ev = {hi, d};
                end
                if (fd) efe = exp_err;
                if (b % 2 == 0) hi = d;
                cycle(last, 1'b1, d, pv, fd);
            end
            if (!(vs_last && l == nlines - 1))
                repeat ($urandom_range(1, 3)) cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        end
        if (!vs_last) begin
            fd = armed;
            if (fd) efe = exp_err;
            cycle(1'b1, 1'b0, 8'h00, 1'b0, fd);
        end
        repeat (2) cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        armed = 1'b1;
    endtask

    initial begin
        int nl, bl, blen;
        #2 reset = 1'b0;
        // Frame already in progress while held in reset, then released mid-line
        for (int b = 0; b < 5; b++) cycle(1'b0, 1'b1, 8'($urandom), 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        for (int b = 0; b < 6; b++) cycle(1'b0, 1'b1, 8'($urandom), 1'b0, 1'b0);
        repeat (2) cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        run_frame(V, -1, 0, 1'b0, 1'b0, -1);

        run_frame(1, -1, 0, 1'b0, 1'b1, -1);          // F800 / 07E0 directed line
        run_frame(V, -1, 0, 1'b0, 1'b0, -1);          // clean full frame
        run_frame(V, 0, 2 * H + 1, 1'b0, 1'b0, -1);   // odd byte count
        run_frame(V + 1, -1, 0, 1'b0, 1'b0, -1);      // one line too many
        run_frame(V, -1, 0, 1'b1, 1'b0, -1);          // vsync on final low byte
        run_frame(V, -1, 0, 1'b0, 1'b0, 5);           // reset mid line 5
        run_frame(V, -1, 0, 1'b0, 1'b0, -1);

        for (int i = 0; i < 16; i++) begin
            nl = V;
            bl = -1;
            blen = 2 * H;
            case ($urandom_range(0, 3))
                1: nl = int'($urandom_range(1, V + 2));
                2: begin
                    bl = int'($urandom_range(0, V - 1));
                    blen = int'($urandom_range(1, 2 * H + 3));
                end
                default: ;
            endcase
            run_frame(nl, bl, blen, 1'($urandom_range(0, 1)), 1'b0, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
